// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional build macro MCF_ILLEGAL_TRAP_EN adds the sticky ILLEGAL trap state.
package mcf_pkg;

    localparam int unsigned ALUOP_W = 3;
    localparam logic [4:0]  RA_REG  = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 3'b100;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALU_WB   = 4'd7,
        IMM_EX   = 4'd8,
        IMM_WB   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
`ifdef MCF_ILLEGAL_TRAP_EN
        , ILLEGAL = 4'd12
`endif
    } state_e;

    // Opcode class latched in DECODE; distinguishes variants sharing a state path.
    typedef enum logic [2:0] {
        OPC_RTYPE = 3'd0,
        OPC_LW    = 3'd1,
        OPC_SW    = 3'd2,
        OPC_BEQ   = 3'd3,
        OPC_BNE   = 3'd4,
        OPC_ADDI  = 3'd5,
        OPC_ORI   = 3'd6,
        OPC_ANDI  = 3'd7
    } opclass_e;

    function automatic logic [ALUOP_W-1:0] imm_aluop(input opclass_e cls);
        logic [ALUOP_W-1:0] op;
        case (cls)
            OPC_ORI:  op = ALUOP_ORI;
            OPC_ANDI: op = ALUOP_ANDI;
            default:  op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_control_fsm_if;
    import mcf_pkg::*;

    logic [5:0]         opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               PCWriteCondN;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUop;
    logic               illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               PCSource, ALUop, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               PCSource, ALUop, illegal_op
    );
endinterface

// File: rtl/multicycle_control_fsm_opdecode.sv
// Combinational opcode classifier used by the FSM in DECODE.
module mcf_opdecode
    import mcf_pkg::*;
(
    input  logic [5:0] opcode_i,
    output opclass_e   opclass_o,
    output logic       is_jump_o,
    output logic       is_legal_o
);

    // Map each supported opcode to its class; jump and undefined are flagged separately.
    always_comb begin
        opclass_o  = OPC_RTYPE;
        is_jump_o  = 1'b0;
        is_legal_o = 1'b1;
        case (opcode_i)
            OP_RTYPE: opclass_o = OPC_RTYPE;
            OP_LW:    opclass_o = OPC_LW;
            OP_SW:    opclass_o = OPC_SW;
            OP_BEQ:   opclass_o = OPC_BEQ;
            OP_BNE:   opclass_o = OPC_BNE;
            OP_ADDI:  opclass_o = OPC_ADDI;
            OP_ORI:   opclass_o = OPC_ORI;
            OP_ANDI:  opclass_o = OPC_ANDI;
            OP_J:     is_jump_o = 1'b1;
            default:  is_legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath; Moore outputs gated by mem_ready in FETCH.
// Build macro MCF_ILLEGAL_TRAP_EN: undefined opcodes trap into a sticky ILLEGAL state.
module multicycle_control_fsm
    import mcf_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    state_e   state_q, state_d;
    opclass_e opclass_q, opclass_d;
    opclass_e dec_class_s;
    logic     dec_jump_s;
    logic     dec_legal_s;

    mcf_opdecode u_opdecode (
        .opcode_i   (bus.opcode),
        .opclass_o  (dec_class_s),
        .is_jump_o  (dec_jump_s),
        .is_legal_o (dec_legal_s)
    );

    // State and latched opcode class registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            opclass_q <= OPC_RTYPE;
        end else begin
            state_q   <= state_d;
            opclass_q <= opclass_d;
        end
    end

    // Next-state and control outputs; reset forces every output low without waiting for a clock.
    always_comb begin
        state_d          = state_q;
        opclass_d        = opclass_q;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.PCWriteCondN = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = SRCB_B;
        bus.PCSource     = PCSRC_ALU;
        bus.ALUop        = ALUOP_ADD;
        bus.illegal_op   = 1'b0;
        if (reset) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_d     = DECODE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DECODE: begin
                    bus.ALUSrcB = SRCB_IMMSH;
                    opclass_d   = dec_class_s;
                    if (dec_jump_s) begin
                        state_d = JUMP;
                    end else if (!dec_legal_s) begin
`ifdef MCF_ILLEGAL_TRAP_EN
                        state_d = ILLEGAL;
`else
                        state_d = FETCH;
`endif
                    end else begin
                        case (dec_class_s)
                            OPC_RTYPE:                    state_d = RTYPE_EX;
                            OPC_LW, OPC_SW:               state_d = MEMADR;
                            OPC_BEQ, OPC_BNE:             state_d = BRANCH;
                            OPC_ADDI, OPC_ORI, OPC_ANDI:  state_d = IMM_EX;
                            default:                      state_d = FETCH;
                        endcase
                    end
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    if (opclass_q == OPC_SW) begin
                        state_d = MEMWR;
                    end else begin
                        state_d = MEMRD;
                    end
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = MEMWB;
                    end else begin
                        state_d = MEMRD;
                    end
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    state_d      = FETCH;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = MEMWR;
                    end
                end
                RTYPE_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUop   = ALUOP_RTYPE;
                    state_d     = ALU_WB;
                end
                ALU_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                    state_d      = FETCH;
                end
                IMM_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ALUop   = imm_aluop(opclass_q);
                    state_d     = IMM_WB;
                end
                IMM_WB: begin
                    bus.RegWrite = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA      = 1'b1;
                    bus.ALUop        = ALUOP_SUB;
                    bus.PCSource     = PCSRC_ALUOUT;
                    bus.PCWriteCond  = (opclass_q == OPC_BEQ);
                    bus.PCWriteCondN = (opclass_q == OPC_BNE);
                    state_d          = FETCH;
                end
                JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PCSRC_JUMP;
                    state_d      = FETCH;
                end
`ifdef MCF_ILLEGAL_TRAP_EN
                ILLEGAL: begin
                    bus.illegal_op = 1'b1;
                    state_d        = ILLEGAL;
                end
`endif
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: compares the whole control word each cycle.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    multicycle_control_fsm_if bus_if ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: PCW PCWC PCWCN IorD MR MW IRW M2R RDst RW SA | SB | PS | ALUop | illegal
    logic [18:0] ctl_s;
    assign ctl_s = {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.PCWriteCondN, bus_if.IorD,
                    bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg,
                    bus_if.RegDst, bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB,
                    bus_if.PCSource, bus_if.ALUop, bus_if.illegal_op};

    localparam logic [18:0] E_RST    = 19'h00000;
    localparam logic [18:0] E_FWAIT  = {11'b00001000000, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_FGO    = {11'b10001010000, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_DEC    = {11'b00000000000, 2'b11, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_MADR   = {11'b00000000001, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_MRD    = {11'b00011000000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_MWB    = {11'b00000001010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_MWR    = {11'b00010100000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_REX    = {11'b00000000001, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_AWB    = {11'b00000000110, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_IADD   = {11'b00000000001, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_IORI   = {11'b00000000001, 2'b10, 2'b00, 3'b011, 1'b0};
    localparam logic [18:0] E_IANDI  = {11'b00000000001, 2'b10, 2'b00, 3'b100, 1'b0};
    localparam logic [18:0] E_IWB    = {11'b00000000010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [18:0] E_BEQ    = {11'b01000000001, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [18:0] E_BNE    = {11'b00100000001, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [18:0] E_JMP    = {11'b10000000000, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [18:0] E_ILL    = {11'b00000000000, 2'b00, 2'b00, 3'b000, 1'b1};

    task automatic check_eq(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs, compare at the falling edge, then let the rising edge advance the FSM.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [18:0] exp,
                       input string tag);
        bus_if.opcode    = op;
        bus_if.mem_ready = rdy;
        @(negedge clk);
        check_eq(tag, ctl_s, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b1;
        bus_if.opcode    = 6'b000000;
        bus_if.mem_ready = 1'b1;
        @(negedge clk);
        check_eq("reset_outputs", ctl_s, E_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // add: mem_ready held high outside FETCH must be ignored
        cyc(6'b000000, 1'b1, E_FGO,  "add_fetch");
        cyc(6'b000000, 1'b1, E_DEC,  "add_decode");
        cyc(6'b000000, 1'b1, E_REX,  "add_rtype_ex");
        cyc(6'b000000, 1'b1, E_AWB,  "add_alu_wb");

        // lw with 3 fetch stalls and 2 read stalls; opcode changes after DECODE
        for (int i = 0; i < 3; i++) cyc(6'b100011, 1'b0, E_FWAIT, "lw_fetch_stall");
        cyc(6'b100011, 1'b1, E_FGO,  "lw_fetch");
        cyc(6'b100011, 1'b0, E_DEC,  "lw_decode");
        cyc(6'b101011, 1'b0, E_MADR, "lw_memadr");
        cyc(6'b101011, 1'b0, E_MRD,  "lw_memrd_stall1");
        cyc(6'b101011, 1'b0, E_MRD,  "lw_memrd_stall2");
        cyc(6'b101011, 1'b1, E_MRD,  "lw_memrd");
        cyc(6'b101011, 1'b1, E_MWB,  "lw_memwb");

        // beq then bne
        cyc(6'b000100, 1'b1, E_FGO,  "beq_fetch");
        cyc(6'b000100, 1'b0, E_DEC,  "beq_decode");
        cyc(6'b000101, 1'b0, E_BEQ,  "beq_branch");
        cyc(6'b000101, 1'b1, E_FGO,  "bne_fetch");
        cyc(6'b000101, 1'b0, E_DEC,  "bne_decode");
        cyc(6'b000100, 1'b0, E_BNE,  "bne_branch");

        // ori, andi, addi
        cyc(6'b001101, 1'b1, E_FGO,  "ori_fetch");
        cyc(6'b001101, 1'b0, E_DEC,  "ori_decode");
        cyc(6'b001100, 1'b0, E_IORI, "ori_imm_ex");
        cyc(6'b001100, 1'b0, E_IWB,  "ori_imm_wb");
        cyc(6'b001100, 1'b1, E_FGO,  "andi_fetch");
        cyc(6'b001100, 1'b0, E_DEC,  "andi_decode");
        cyc(6'b001101, 1'b0, E_IANDI,"andi_imm_ex");
        cyc(6'b001101, 1'b0, E_IWB,  "andi_imm_wb");
        cyc(6'b001000, 1'b1, E_FGO,  "addi_fetch");
        cyc(6'b001000, 1'b0, E_DEC,  "addi_decode");
        cyc(6'b001000, 1'b0, E_IADD, "addi_imm_ex");
        cyc(6'b001000, 1'b0, E_IWB,  "addi_imm_wb");

        // jump
        cyc(6'b000010, 1'b1, E_FGO,  "j_fetch");
        cyc(6'b000010, 1'b0, E_DEC,  "j_decode");
        cyc(6'b000010, 1'b0, E_JMP,  "j_jump");

        // sw with one write stall
        cyc(6'b101011, 1'b1, E_FGO,  "sw_fetch");
        cyc(6'b101011, 1'b0, E_DEC,  "sw_decode");
        cyc(6'b100011, 1'b0, E_MADR, "sw_memadr");
        cyc(6'b100011, 1'b0, E_MWR,  "sw_memwr_stall");
        cyc(6'b100011, 1'b1, E_MWR,  "sw_memwr");
        cyc(6'b000000, 1'b0, E_FWAIT,"sw_back_to_fetch");

        // sw interrupted by asynchronous reset in MEMWR
        cyc(6'b101011, 1'b1, E_FGO,  "swr_fetch");
        cyc(6'b101011, 1'b0, E_DEC,  "swr_decode");
        cyc(6'b101011, 1'b0, E_MADR, "swr_memadr");
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("swr_memwr", ctl_s, E_MWR);
        #2;
        reset = 1'b1;
        #1;
        check_eq("swr_async_reset", ctl_s, E_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(6'b000000, 1'b0, E_FWAIT,"swr_post_reset_fetch");

        // undefined opcode 111111
        cyc(6'b111111, 1'b1, E_FGO,  "ill_fetch");
        cyc(6'b111111, 1'b1, E_DEC,  "ill_decode");
`ifdef MCF_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc(6'b000000, 1'b1, E_ILL, "ill_sticky");
        reset = 1'b1;
        #1;
        check_eq("ill_reset", ctl_s, E_RST);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(6'b000000, 1'b0, E_FWAIT,"ill_post_reset_fetch");
`else
        cyc(6'b111111, 1'b0, E_FWAIT,"ill_noop_fetch");
        cyc(6'b000000, 1'b1, E_FGO,  "ill_next_fetch");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
